// File: rtl/tlv2548_pkg.sv
// Shared definitions for the TLV2548 scan sequencer: opcodes, FSM states,
// result width and small command helpers.
package tlv2548_pkg;

  localparam int RES_W  = 12;
  localparam int NUM_CH = 8;

  // Upper nibble of the 16-bit command word. Select-channel uses bit 15 = 0
  // and carries the channel number in bits 14:12.
  localparam logic [3:0] CMD_SEL     = 4'b0000;
  localparam logic [3:0] CMD_CFR_WR  = 4'hA;
  localparam logic [3:0] CMD_CFR_RD  = 4'h9;
  localparam logic [3:0] CMD_FIFO_RD = 4'hE;
  localparam logic [3:0] CMD_HW_DEF  = 4'hF;

  typedef enum logic [2:0] {
    CFG_SEND, CFG_WAIT, GAP, IDLE, CH_SEND, CH_WAIT, FLUSH_SEND, FLUSH_WAIT
  } state_e;

  // Lowest enabled channel; 0 when the mask is empty.
  function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] mask);
    first_ch = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i]) first_ch = 3'(i);
  endfunction

  // Select-channel frame for channel ch.
  function automatic logic [15:0] sel_cmd(input logic [2:0] ch);
    sel_cmd = {CMD_SEL[3], ch, 12'h000};
  endfunction

endpackage

// File: rtl/tlv2548_ch_pick.sv
// Next-enabled-channel priority encoder: finds the lowest enabled channel
// strictly above cur_i. last_o flags that no such channel exists.
module tlv2548_ch_pick
  import tlv2548_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [2:0]        cur_i,
  output logic [2:0]        nxt_o,
  output logic              last_o
);

  // Scan from the top down so the lowest qualifying channel wins.
  always_comb begin
    nxt_o  = cur_i;
    last_o = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (3'(i) > cur_i)) begin
        nxt_o  = 3'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlv2548_seq.sv
// TLV2548 scan sequencer: writes the CFR after reset, then on request walks
// the enabled channels, re-aligning the one-frame-late ADC results to their
// channel numbers.
module tlv2548_seq
  import tlv2548_pkg::*;
#(
  parameter logic [11:0]       P_CFR     = 12'h0C0,
  parameter logic [NUM_CH-1:0] P_CH_MASK = 8'hFF,
  parameter int                P_GAP     = 4,
  parameter int                P_TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_continuous,
  output logic [15:0]      o_tx_data,
  output logic             o_tx_en,
  input  logic             i_tx_ready,
  input  logic [RES_W-1:0] i_rx_data,
  input  logic             i_rx_valid,
  output logic [RES_W-1:0] o_data,
  output logic [2:0]       o_ch,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_cfg_done,
  output logic             o_err
);

  localparam int              CW       = $clog2(P_TIMEOUT + P_GAP + 1) + 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(P_TIMEOUT - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(P_GAP - 1);
  localparam logic [2:0]      FIRST_CH = first_ch(P_CH_MASK);

  state_e           state_q, gap_nxt_q;
  logic [CW-1:0]    cnt_q;        // timeout counter in *_WAIT, gap counter in GAP
  logic [2:0]       cur_ch_q;     // channel of the frame being sent / in flight
  logic [2:0]       prev_ch_q;    // channel whose result the next rx carries
  logic             first_q;      // next CH result is the stale one to discard
  logic [15:0]      tx_data_q;
  logic             tx_en_q, valid_q, busy_q, cfg_done_q, err_q;
  logic [RES_W-1:0] data_q;
  logic [2:0]       ch_q;
  logic [2:0]       pick_nxt;
  logic             pick_last, tmo;

  tlv2548_ch_pick u_pick (
    .mask_i (P_CH_MASK),
    .cur_i  (cur_ch_q),
    .nxt_o  (pick_nxt),
    .last_o (pick_last)
  );

  assign tmo = (cnt_q == TMO_LAST);

  // Sequencer FSM with registered outputs; GAP always sits between frames
  // and gap_nxt_q remembers where to go once it expires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= CFG_SEND;
      gap_nxt_q  <= IDLE;
      cnt_q      <= '0;
      cur_ch_q   <= FIRST_CH;
      prev_ch_q  <= FIRST_CH;
      first_q    <= 1'b1;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        CFG_SEND: begin
          busy_q <= 1'b1;
          if (i_tx_ready) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= {CMD_CFR_WR, P_CFR};
            cnt_q     <= '0;
            state_q   <= CFG_WAIT;
          end
        end
        CFG_WAIT: begin
          if (i_rx_valid) begin
            cfg_done_q <= 1'b1;
            gap_nxt_q  <= IDLE;
            cnt_q      <= '0;
            state_q    <= GAP;
          end else if (tmo) begin
            err_q     <= 1'b1;
            gap_nxt_q <= CFG_SEND;   // retry the configuration write
            cnt_q     <= '0;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= gap_nxt_q;
            if (gap_nxt_q == IDLE) busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (i_start && (P_CH_MASK != '0)) begin
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            cur_ch_q <= FIRST_CH;
            first_q  <= 1'b1;
            state_q  <= CH_SEND;
          end
        end
        CH_SEND: begin
          if (i_tx_ready) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= sel_cmd(cur_ch_q);
            cnt_q     <= '0;
            state_q   <= CH_WAIT;
          end
        end
        CH_WAIT: begin
          if (i_rx_valid) begin
            if (!first_q) begin
              valid_q <= 1'b1;
              data_q  <= i_rx_data;
              ch_q    <= prev_ch_q;
            end
            first_q   <= 1'b0;
            prev_ch_q <= cur_ch_q;
            if (pick_last) begin
              gap_nxt_q <= FLUSH_SEND;
            end else begin
              cur_ch_q  <= pick_nxt;
              gap_nxt_q <= CH_SEND;
            end
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (tmo) begin
            err_q     <= 1'b1;
            gap_nxt_q <= IDLE;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FLUSH_SEND: begin
          // Dummy select only clocks out the last channel's result.
          if (i_tx_ready) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= sel_cmd(FIRST_CH);
            cnt_q     <= '0;
            state_q   <= FLUSH_WAIT;
          end
        end
        FLUSH_WAIT: begin
          if (i_rx_valid) begin
            valid_q <= 1'b1;
            data_q  <= i_rx_data;
            ch_q    <= prev_ch_q;
            if (i_continuous) begin
              cur_ch_q  <= FIRST_CH;
              first_q   <= 1'b1;
              gap_nxt_q <= CH_SEND;
            end else begin
              gap_nxt_q <= IDLE;
            end
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (tmo) begin
            err_q     <= 1'b1;
            gap_nxt_q <= IDLE;
            cnt_q     <= '0;
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_en    = tx_en_q;
  assign o_data     = data_q;
  assign o_ch       = ch_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_cfg_done = cfg_done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_tlv2548_seq.sv
// Bench for tlv2548_seq: two sequencers (mask 05 / gap 2, mask 80 / gap 4)
// each driven by a simple SPI driver model with a fixed 3-cycle latency.
module tb_tlv2548_seq;

  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [2];
  logic        start [2];
  logic        cont [2];
  logic        tx_ready [2] = '{1'b1, 1'b1};
  logic        rx_valid [2] = '{1'b0, 1'b0};
  logic [11:0] rx_data [2] = '{12'h0, 12'h0};
  logic [15:0] tx_data [2];
  logic        tx_en [2];
  logic [11:0] o_data [2];
  logic [2:0]  o_ch [2];
  logic        valid [2], busy [2], cfg_done [2], err [2];

  tlv2548_seq #(.P_CFR(12'h0C0), .P_CH_MASK(8'h05), .P_GAP(2), .P_TIMEOUT(TMO)) u_a (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_continuous(cont[0]),
    .o_tx_data(tx_data[0]), .o_tx_en(tx_en[0]), .i_tx_ready(tx_ready[0]),
    .i_rx_data(rx_data[0]), .i_rx_valid(rx_valid[0]), .o_data(o_data[0]), .o_ch(o_ch[0]),
    .o_valid(valid[0]), .o_busy(busy[0]), .o_cfg_done(cfg_done[0]), .o_err(err[0]));

  tlv2548_seq #(.P_CFR(12'h0C0), .P_CH_MASK(8'h80), .P_GAP(4), .P_TIMEOUT(TMO)) u_b (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_continuous(cont[1]),
    .o_tx_data(tx_data[1]), .o_tx_en(tx_en[1]), .i_tx_ready(tx_ready[1]),
    .i_rx_data(rx_data[1]), .i_rx_valid(rx_valid[1]), .o_data(o_data[1]), .o_ch(o_ch[1]),
    .o_valid(valid[1]), .o_busy(busy[1]), .o_cfg_done(cfg_done[1]), .o_err(err[1]));

  // Stimulus-side state (written only by the initial block)
  logic [11:0] rq [2][$];        // replies the model returns, in frame order
  logic [15:0] exp_fr [2][$];    // expected frame words
  logic [14:0] exp_smp [2][$];   // expected {ch, data}
  logic        withhold [2] = '{1'b0, 1'b0};
  int          rdf [2] = '{0, 0};
  int          rds [2] = '{0, 0};
  int          checks = 0;
  int          failures = 0;

  // Model-side state (written only by the model block)
  logic [15:0] obs_fr [2][$];
  logic [14:0] obs_smp [2][$];
  int          rq_rd [2] = '{0, 0};
  int          bcnt [2] = '{0, 0};
  logic        drop [2] = '{1'b0, 1'b0};
  int          nfr [2] = '{0, 0};
  int          viol [2] = '{0, 0};
  int          lowrun [2] = '{0, 0};
  int          mingap [2] = '{1000, 1000};
  int          txcyc [2] = '{0, 0};

  // SPI driver model and output monitor, evaluated away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rx_valid[k] = 1'b0;
      if (bcnt[k] != 0) begin
        bcnt[k] = bcnt[k] - 1;
        if (bcnt[k] == 0) begin
          if (!drop[k]) begin
            rx_valid[k] = 1'b1;
            rx_data[k]  = (rq_rd[k] < rq[k].size()) ? rq[k][rq_rd[k]] : 12'h000;
            rq_rd[k]    = rq_rd[k] + 1;
          end
          tx_ready[k] = 1'b1;
        end
      end
      if (tx_en[k] === 1'b1) begin
        if (!tx_ready[k]) viol[k] = viol[k] + 1;
        if (nfr[k] > 0 && lowrun[k] < mingap[k]) mingap[k] = lowrun[k];
        lowrun[k] = 0;
        nfr[k]    = nfr[k] + 1;
        obs_fr[k].push_back(tx_data[k]);
        txcyc[k]    = cyc;
        tx_ready[k] = 1'b0;
        bcnt[k]     = 3;
        drop[k]     = withhold[k];
      end else begin
        lowrun[k] = lowrun[k] + 1;
      end
      if (valid[k] === 1'b1) obs_smp[k].push_back({o_ch[k], o_data[k]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    tick(3);
    while (busy[k] && n < 3000) begin
      tick(1);
      n++;
    end
    chk("idle_wait", busy[k], 0);
  endtask

  // Compare everything the DUT produced since the last drain against the scoreboard
  task automatic drain(input int k, input string tag);
    int nf, ns;
    nf = obs_fr[k].size() - rdf[k];
    ns = obs_smp[k].size() - rds[k];
    chk({tag, "_nframes"}, nf, exp_fr[k].size());
    for (int i = 0; i < exp_fr[k].size() && i < nf; i++)
      chk({tag, "_frame"}, obs_fr[k][rdf[k] + i], exp_fr[k][i]);
    chk({tag, "_nsamples"}, ns, exp_smp[k].size());
    for (int i = 0; i < exp_smp[k].size() && i < ns; i++)
      chk({tag, "_sample"}, obs_smp[k][rds[k] + i], exp_smp[k][i]);
    rdf[k] += nf;
    rds[k] += ns;
    exp_fr[k].delete();
    exp_smp[k].delete();
  endtask

  initial begin
    int n, nb, errc;
    logic saw_busy;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    cont[0] = 1'b0; cont[1] = 1'b0;
    tick(3);

    // Reset state
    chk("rst_tx_data", tx_data[0], 0);
    chk("rst_tx_en", tx_en[0], 0);
    chk("rst_data", o_data[0], 0);
    chk("rst_ch", o_ch[0], 0);
    chk("rst_valid", valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_cfg_done", cfg_done[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_outs_b", {tx_data[1], tx_en[1], o_data[1], o_ch[1], valid[1], busy[1],
                       cfg_done[1], err[1]}, 0);

    // Configuration write after reset release
    for (int k = 0; k < 2; k++) begin
      exp_fr[k].push_back(16'hA0C0);
      rq[k].push_back(12'hFFF);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    n = 0; saw_busy = 1'b0;
    while (!(cfg_done[0] && cfg_done[1] && !busy[0] && !busy[1]) && n < 300) begin
      tick(1);
      if (busy[0]) saw_busy = 1'b1;
      n++;
    end
    chk("cfg_done_a", cfg_done[0], 1);
    chk("cfg_done_b", cfg_done[1], 1);
    chk("cfg_busy_rose", saw_busy, 1);
    chk("cfg_busy_fell", busy[0], 0);
    drain(0, "cfg_a");
    drain(1, "cfg_b");

    // Two-channel scan with a start pulse landing mid-scan
    rq[0].push_back(12'h111); rq[0].push_back(12'h222); rq[0].push_back(12'h333);
    exp_fr[0].push_back(16'h0000); exp_fr[0].push_back(16'h2000); exp_fr[0].push_back(16'h0000);
    exp_smp[0].push_back({3'd0, 12'h222}); exp_smp[0].push_back({3'd2, 12'h333});
    pulse_start(0);
    tick(8);
    chk("scan_busy", busy[0], 1);
    pulse_start(0);
    wait_idle(0);
    drain(0, "scan_a");
    chk("hold_data", o_data[0], 12'h333);
    chk("hold_ch", o_ch[0], 2);
    chk("scan_nfr", nfr[0], 4);

    // Timeout: first CH frame gets no result
    withhold[0] = 1'b1;
    exp_fr[0].push_back(16'h0000);
    pulse_start(0);
    n = 0;
    while (!err[0] && n < 300) begin
      tick(1);
      n++;
    end
    errc = cyc;
    withhold[0] = 1'b0;
    chk("tmo_err", err[0], 1);
    chk("tmo_latency", errc - txcyc[0], TMO);
    wait_idle(0);
    chk("tmo_err_sticky", err[0], 1);
    drain(0, "tmo");

    // Next start clears the error and scans normally
    rq[0].push_back(12'h444); rq[0].push_back(12'h555); rq[0].push_back(12'h666);
    exp_fr[0].push_back(16'h0000); exp_fr[0].push_back(16'h2000); exp_fr[0].push_back(16'h0000);
    exp_smp[0].push_back({3'd0, 12'h555}); exp_smp[0].push_back({3'd2, 12'h666});
    pulse_start(0);
    chk("err_clear", err[0], 0);
    wait_idle(0);
    drain(0, "rescan_a");

    // Continuous single-channel scans on the second sequencer
    cont[1] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rq[1].push_back(12'(i * 12'h100));
      exp_fr[1].push_back(16'h7000);
    end
    exp_smp[1].push_back({3'd7, 12'h200});
    exp_smp[1].push_back({3'd7, 12'h400});
    exp_smp[1].push_back({3'd7, 12'h600});
    pulse_start(1);
    n = 0;
    while (nfr[1] < 6 && n < 500) begin
      tick(1);
      n++;
    end
    cont[1] = 1'b0;
    wait_idle(1);
    drain(1, "cont_b");
    chk("cont_nfr", nfr[1], 7);

    // Frame spacing and handshake
    chk("gap_a_min", mingap[0] >= 2, 1);
    chk("gap_b_min", mingap[1] >= 4, 1);
    chk("tx_en_not_ready_a", viol[0], 0);
    chk("tx_en_not_ready_b", viol[1], 0);

    // Reset while a CH frame is in flight
    rq[0].push_back(12'h777);
    exp_fr[0].push_back(16'h0000);
    nb = nfr[0];
    pulse_start(0);
    n = 0;
    while (nfr[0] == nb && n < 100) begin
      tick(1);
      n++;
    end
    chk("midrst_frame_sent", nfr[0], nb + 1);
    #2 rst[0] = 1'b1;
    #1 chk("midrst_async", {tx_data[0], tx_en[0], o_data[0], o_ch[0], valid[0], busy[0],
                            cfg_done[0], err[0]}, 0);
    tick(2);
    exp_fr[0].push_back(16'hA0C0);
    rq[0].push_back(12'hFFF);
    rst[0] = 1'b0;
    n = 0;
    while (!cfg_done[0] && n < 300) begin
      tick(1);
      n++;
    end
    chk("midrst_cfg_done", cfg_done[0], 1);
    wait_idle(0);
    drain(0, "midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlv2548_seq.md
# tlv2548_seq

Scan sequencer for the TLV2548 8-channel 12-bit ADC. After reset it writes the ADC configuration register (CFR) through the existing 16-bit SPI driver. On request it then walks the enabled channels in ascending order, issuing one select-channel frame per channel. The ADC returns each conversion one frame late, so the sequencer re-aligns the 12-bit results to their channel numbers and presents them as a valid stream. It sits between the SPI driver and the sample-consuming logic (filters, FIFO, host registers).

## Interface
Parameters:
- P_CFR, 12'h0C0: CFR payload sent in the `{4'hA, P_CFR}` command.
- P_CH_MASK, 8'hFF: channel enable mask; bit n enables channel n.
- P_GAP, 4: idle clocks between frames; minimum 2.
- P_TIMEOUT, 4096: clocks allowed from o_tx_en to i_rx_valid.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_start, in, 1: one-cycle pulse; start a scan.
- i_continuous, in, 1: sampled at end of scan; 1 = restart automatically.
- o_tx_data, out, 16: command word to SPI driver.
- o_tx_en, out, 1: one-cycle frame request to SPI driver.
- i_tx_ready, in, 1: SPI driver idle.
- i_rx_data, in, 12: result from SPI driver.
- i_rx_valid, in, 1: one-cycle result strobe from SPI driver.
- o_data, out, 12: aligned sample.
- o_ch, out, 3: channel of o_data.
- o_valid, out, 1: one-cycle sample strobe.
- o_busy, out, 1: config or scan in progress.
- o_cfg_done, out, 1: CFR write completed.
- o_err, out, 1: sticky timeout flag; cleared on the next accepted i_start.

## Operation
- Reset values: o_tx_data=0, o_tx_en=0, o_data=0, o_ch=0, o_valid=0, o_busy=0, o_cfg_done=0, o_err=0; FSM in CFG_SEND.
- States:
  - CFG_SEND → CFG_WAIT → GAP → IDLE.
  - IDLE → CH_SEND → CH_WAIT → GAP → CH_SEND … → FLUSH_SEND → FLUSH_WAIT → GAP → IDLE, or back to CH_SEND if i_continuous=1.
- *_SEND states:
  - Wait for i_tx_ready=1, then drive o_tx_en=1 for exactly one cycle with o_tx_data valid in that cycle.
  - Move to the matching *_WAIT state.
- CFG_SEND: command `{4'hA, P_CFR}`. The result of that frame is discarded. o_cfg_done is set to 1 on exit from CFG_WAIT and stays 1 until reset.
- CH_SEND: command `{1'b0, ch[2:0], 12'h000}`, where ch is the next enabled channel in ascending order.
- FLUSH_SEND: repeats the first enabled channel's select command; its only purpose is to clock out the last channel's result.
- Result alignment:
  - The i_rx_valid of the first CH frame in a scan is discarded.
  - Every later i_rx_valid (including FLUSH) produces o_valid=1, with o_data=i_rx_data and o_ch equal to the channel selected in the previous frame.
  - An N-channel scan therefore produces exactly N samples from N+1 frames.
- IDLE:
  - i_start with P_CH_MASK≠0 begins a scan and clears o_err.
  - i_start is ignored in every non-IDLE state, and also when P_CH_MASK=0.
- Timeout:
  - In any *_WAIT state, a cycle counter starts at o_tx_en.
  - Reaching P_TIMEOUT sets o_err=1 and returns to IDLE without emitting o_valid.
  - Partial-scan samples already emitted stand.
  - If the timeout occurs during CFG, o_cfg_done stays 0 and the FSM retries CFG_SEND after the GAP.
- o_busy = 1 in every state except IDLE.
- Reset mid-frame: all outputs return to their reset values asynchronously. After reset release the CFR is rewritten. Any in-flight SPI result is ignored because the FSM is not in a WAIT state.

## Timing
- o_tx_en is high for exactly one cycle. It is low for at least P_GAP cycles between frames, so the SPI driver always sees a fresh rising edge.
- o_valid is asserted in the cycle after i_rx_valid; o_data and o_ch are registered and held until the next o_valid.
- GAP is counted from the cycle after i_rx_valid. The next *_SEND then additionally waits for i_tx_ready.
- Channel selection: the next enabled channel is a priority search above the current index. A scan always restarts from the lowest set bit; there is no wrap within a scan.
- Continuous mode: the FLUSH frame of one scan is not reused; each scan independently discards its first result.

## Structure
- Shared package `tlv2548_pkg`:
  - command opcodes: CMD_SEL=4'b0xxx, CMD_CFR_WR=4'hA, CMD_CFR_RD=4'h9, CMD_FIFO_RD=4'hE, CMD_HW_DEF=4'hF;
  - the state enum;
  - the 12-bit result width.
- One natural sub-module, `tlv2548_ch_pick`: combinational next-enabled-channel priority encoder. Inputs: mask and current index. Outputs: next index and a last flag.

## Test plan
- Reset release with the SPI driver model → first frame 16'hA0C0; o_cfg_done=1 after its i_rx_valid; o_busy falls 1→0.
- P_CH_MASK=8'h05, i_start, model returns 12'h111 then 12'h222 then 12'h333 → frames 16'h0000, 16'h2000, 16'h0000; outputs (ch0, 12'h222) then (ch2, 12'h333); 12'h111 discarded.
- i_continuous=1, mask 8'h80 → repeating frame pairs 16'h7000, 16'h7000; each pair yields one o_valid with o_ch=7.
- Model withholds i_rx_valid during a CH frame → o_err=1 at P_TIMEOUT, FSM back to IDLE; next i_start clears o_err.
- i_start pulsed mid-scan → ignored, frame count unchanged. Assert i_rst during CH_WAIT → all outputs zero immediately; next frame after release is the CFR write.
- P_GAP=2 → measure ≥2 low cycles of o_tx_en between frames, and o_tx_en never high while i_tx_ready=0.
